// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the I/D cache memory arbiter.
package mem_arb_pkg;
  localparam int WORD_SIZE_DEF = 16;
  localparam int MEM_BW_DEF    = 64;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2,
    RESP   = 2'd3
  } state_t;

  localparam logic [1:0] OWN_NONE = 2'b00;
  localparam logic [1:0] OWN_I    = 2'b01;
  localparam logic [1:0] OWN_D    = 2'b10;
endpackage

// File: rtl/arb_pick.sv
// Combinational winner select. MEM_ARB_RR_EN: alternate on contention, else D always wins.
module arb_pick (
  input  logic i_req,
  input  logic d_req,
  input  logic last_served,
  output logic grant_d
);
`ifdef MEM_ARB_RR_EN
  // last_served: 0 = I, 1 = D; on a tie the other side wins
  assign grant_d = d_req & (~i_req | ~last_served);
`else
  logic unused_last_served;
  assign unused_last_served = last_served;
  assign grant_d = d_req;
`endif
endmodule

// File: rtl/mem_arbiter.sv
// Two-requester (I/D cache) arbiter onto one line-wide memory port.
// Optional MEM_ARB_RR_EN selects round-robin on contention instead of fixed D priority.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int WORD_SIZE        = WORD_SIZE_DEF,
  parameter int MEMORY_BANDWIDTH = MEM_BW_DEF
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        i_req,
  input  logic                        i_we,
  input  logic [WORD_SIZE-1:0]        i_addr,
  input  logic [MEMORY_BANDWIDTH-1:0] i_wdata,
  output logic [MEMORY_BANDWIDTH-1:0] i_rdata,
  output logic                        i_ack,
  input  logic                        d_req,
  input  logic                        d_we,
  input  logic [WORD_SIZE-1:0]        d_addr,
  input  logic [MEMORY_BANDWIDTH-1:0] d_wdata,
  output logic [MEMORY_BANDWIDTH-1:0] d_rdata,
  output logic                        d_ack,
  output logic                        m_req,
  output logic                        m_we,
  output logic [WORD_SIZE-1:0]        m_addr,
  output logic [MEMORY_BANDWIDTH-1:0] m_wdata,
  input  logic [MEMORY_BANDWIDTH-1:0] m_rdata,
  input  logic                        m_ack,
  output logic [1:0]                  owner
);
  state_t state;
  logic   grant_d;
  logic   last_served;

`ifdef MEM_ARB_RR_EN
  logic last_d;
  assign last_served = last_d;
`else
  assign last_served = 1'b0;
`endif

  arb_pick u_pick (
    .i_req      (i_req),
    .d_req      (d_req),
    .last_served(last_served),
    .grant_d    (grant_d)
  );

  // m_* outputs come straight from the latched request copy, so requester
  // changes during service cannot leak onto the memory port.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      owner   <= OWN_NONE;
      m_req   <= 1'b0;
      m_we    <= 1'b0;
      m_addr  <= '0;
      m_wdata <= '0;
      i_rdata <= '0;
      d_rdata <= '0;
      i_ack   <= 1'b0;
      d_ack   <= 1'b0;
`ifdef MEM_ARB_RR_EN
      last_d  <= 1'b0;
`endif
    end else begin
      i_ack <= 1'b0;
      d_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (i_req || d_req) begin
            m_req <= 1'b1;
            if (grant_d) begin
              state   <= BUSY_D;
              owner   <= OWN_D;
              m_we    <= d_we;
              m_addr  <= d_addr;
              m_wdata <= d_wdata;
            end else begin
              state   <= BUSY_I;
              owner   <= OWN_I;
              m_we    <= i_we;
              m_addr  <= i_addr;
              m_wdata <= i_wdata;
            end
`ifdef MEM_ARB_RR_EN
            last_d <= grant_d;
`endif
          end
        end
        BUSY_I, BUSY_D: begin
          if (m_ack) begin
            m_req <= 1'b0;
            state <= RESP;
            if (state == BUSY_D) begin
              d_ack <= 1'b1;
              if (!m_we) d_rdata <= m_rdata;
            end else begin
              i_ack <= 1'b1;
              if (!m_we) i_rdata <= m_rdata;
            end
          end
        end
        RESP: begin
          state <= IDLE;
          owner <= OWN_NONE;
          m_we  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
